// File: rtl/msrv32_instr_fetch.sv
// Instruction-fetch reader: one outstanding word request, buffers the returned
// instruction with its PC for decode, holds under stall, drops on flush.
`timescale 1ns/1ps
module msrv32_instr_fetch #(
  parameter logic [31:0] boot_address = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] pc_in,
  input  logic        flush_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_valid_out,
  output logic        misaligned_out,
  output logic        pc_advance_out
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ_S, WAIT_S, HOLD_S} state_t;

  state_t          state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] instr_d, instr_pc_d;
  logic            valid_d, mis_d;
  logic            req_c, adv_c;

  // State and presentation registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q         <= REQ_S;
      drop_q          <= 1'b0;
      req_pc_q        <= '0;
      instr_out       <= NOP;
      instr_pc_out    <= boot_address;
      instr_valid_out <= 1'b0;
      misaligned_out  <= 1'b0;
    end else begin
      state_q         <= state_d;
      drop_q          <= drop_d;
      req_pc_q        <= req_pc_d;
      instr_out       <= instr_d;
      instr_pc_out    <= instr_pc_d;
      instr_valid_out <= valid_d;
      misaligned_out  <= mis_d;
    end
  end

  // Next-state, next-register and request/advance strobes
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_out;
    instr_pc_d = instr_pc_out;
    valid_d    = instr_valid_out;
    mis_d      = misaligned_out;
    req_c      = 1'b0;
    adv_c      = 1'b0;

    unique case (state_q)
      REQ_S: begin
        if (!flush_in) begin
          if (pc_in[1:0] == 2'b00) begin
            req_c = 1'b1;
            if (imem_gnt_in) begin
              req_pc_d = pc_in;
              drop_d   = flush_in;
              state_d  = WAIT_S;
            end
          end else begin
            // Misaligned PC becomes a presented fault entry with no bus traffic
            instr_d    = NOP;
            instr_pc_d = pc_in;
            mis_d      = 1'b1;
            valid_d    = 1'b1;
            state_d    = HOLD_S;
          end
        end
      end
      WAIT_S: begin
        if (flush_in) drop_d = 1'b1;
        if (imem_rvalid_in) begin
          if (drop_q || flush_in) begin
            drop_d  = 1'b0;
            state_d = REQ_S;
          end else begin
            instr_d    = imem_rdata_in;
            instr_pc_d = req_pc_q;
            mis_d      = 1'b0;
            valid_d    = 1'b1;
            state_d    = HOLD_S;
          end
        end
      end
      HOLD_S: begin
        if (flush_in) begin
          valid_d = 1'b0;
          mis_d   = 1'b0;
          state_d = REQ_S;
        end else if (!stall_in) begin
          adv_c   = 1'b1;
          valid_d = 1'b0;
          state_d = REQ_S;
        end
      end
      default: state_d = REQ_S;
    endcase
  end

  assign imem_req_out   = req_c & rst_in;
  assign pc_advance_out = adv_c & rst_in;
  assign imem_addr_out  = {pc_in[31:2], 2'b00};

endmodule

// File: tb/tb_msrv32_instr_fetch.sv
// Self-checking bench for msrv32_instr_fetch: directed scenarios plus a random
// run against a PC-register/memory reference model.
`timescale 1ns/1ps
module tb_msrv32_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] pc_in;
  logic        flush_in, stall_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in, imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out, instr_pc_out;
  logic        instr_valid_out, misaligned_out, pc_advance_out;

  int checks = 0;
  int errors = 0;

  msrv32_instr_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in),
    .flush_in(flush_in), .stall_in(stall_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in),
    .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out), .instr_pc_out(instr_pc_out),
    .instr_valid_out(instr_valid_out), .misaligned_out(misaligned_out),
    .pc_advance_out(pc_advance_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    imem_gnt_in    = 1'b0;
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = '0;
    flush_in       = 1'b0;
    stall_in       = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    idle_inputs();
    pc_in  = pc;
    rst_in = 1'b0;
    repeat (3) tick();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_in  = 32'h0;
    rst_in = 1'b0;
    repeat (3) tick();
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid_out); end
    checks++; if (instr_pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 00000000", instr_pc_out); end
    checks++; if (instr_out !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", instr_out, NOP); end
    checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req_out); end
    checks++; if (misaligned_out !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", misaligned_out); end
    rst_in = 1'b1;
    #1;
    checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL rel_req got %b exp 1", imem_req_out); end
    checks++; if (imem_addr_out !== 32'h0) begin errors++; $display("FAIL rel_addr got %h exp 00000000", imem_addr_out); end
  endtask

  task automatic test_basic_fetch();
    do_reset(32'h100);
    imem_gnt_in = 1'b1;
    #1;
    checks++; if (imem_addr_out !== 32'h100) begin errors++; $display("FAIL basic_addr got %h exp 00000100", imem_addr_out); end
    tick();
    imem_gnt_in    = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'h0050_0093;
    tick();
    imem_rvalid_in = 1'b0;
    #1;
    checks++; if (instr_valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", instr_valid_out); end
    checks++; if (instr_out !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", instr_out); end
    checks++; if (instr_pc_out !== 32'h100) begin errors++; $display("FAIL basic_pc got %h exp 00000100", instr_pc_out); end
    checks++; if (pc_advance_out !== 1'b1) begin errors++; $display("FAIL basic_adv got %b exp 1", pc_advance_out); end
    tick();
    pc_in = 32'h104;
    #1;
    checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL basic_nreq got %b exp 1", imem_req_out); end
    checks++; if (imem_addr_out !== 32'h104) begin errors++; $display("FAIL basic_naddr got %h exp 00000104", imem_addr_out); end
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got %b exp 0", instr_valid_out); end
  endtask

  task automatic test_stall();
    do_reset(32'h104);
    imem_gnt_in = 1'b1;
    tick();
    imem_gnt_in    = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'h00A0_0113;
    tick();
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = 32'hFFFF_FFFF;
    stall_in       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (instr_valid_out !== 1'b1 || instr_out !== 32'h00A0_0113 || instr_pc_out !== 32'h104)
        begin errors++; $display("FAIL stall_hold cyc %0d got v=%b i=%h pc=%h exp v=1 i=00a00113 pc=00000104", i, instr_valid_out, instr_out, instr_pc_out); end
      checks++; if (pc_advance_out !== 1'b0 || imem_req_out !== 1'b0)
        begin errors++; $display("FAIL stall_quiet cyc %0d got adv=%b req=%b exp 0 0", i, pc_advance_out, imem_req_out); end
      tick();
    end
    stall_in = 1'b0;
    #1;
    checks++; if (pc_advance_out !== 1'b1) begin errors++; $display("FAIL stall_release_adv got %b exp 1", pc_advance_out); end
    tick();
    pc_in = 32'h108;
    #1;
    checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h108)
      begin errors++; $display("FAIL stall_next_req got req=%b addr=%h exp 1 00000108", imem_req_out, imem_addr_out); end
  endtask

  task automatic test_flush_inflight();
    int seen;
    seen = 0;
    do_reset(32'h100);
    imem_gnt_in = 1'b1;
    tick();
    imem_gnt_in = 1'b0;
    flush_in    = 1'b1;
    pc_in       = 32'h200;
    tick();
    flush_in       = 1'b0;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (instr_valid_out !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_valid got %0d valid cycles exp 0", seen); end
    checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200)
      begin errors++; $display("FAIL flush_redirect got req=%b addr=%h exp 1 00000200", imem_req_out, imem_addr_out); end
  endtask

  task automatic test_misaligned();
    do_reset(32'h102);
    imem_gnt_in = 1'b1;
    #1;
    checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", imem_req_out); end
    tick();
    imem_gnt_in = 1'b0;
    stall_in    = 1'b1;
    #1;
    checks++; if (instr_valid_out !== 1'b1 || misaligned_out !== 1'b1)
      begin errors++; $display("FAIL mis_flags got v=%b m=%b exp 1 1", instr_valid_out, misaligned_out); end
    checks++; if (instr_pc_out !== 32'h102 || instr_out !== NOP)
      begin errors++; $display("FAIL mis_entry got pc=%h i=%h exp 00000102 00000013", instr_pc_out, instr_out); end
    // Flush beats stall in HOLD_S
    flush_in = 1'b1;
    #1;
    checks++; if (pc_advance_out !== 1'b0) begin errors++; $display("FAIL mis_flush_adv got %b exp 0", pc_advance_out); end
    tick();
    flush_in = 1'b0;
    stall_in = 1'b0;
    #1;
    checks++; if (instr_valid_out !== 1'b0 || misaligned_out !== 1'b0)
      begin errors++; $display("FAIL mis_flush_clear got v=%b m=%b exp 0 0", instr_valid_out, misaligned_out); end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h100);
    imem_gnt_in = 1'b1;
    tick();
    imem_gnt_in = 1'b0;
    rst_in      = 1'b0;
    #1;
    checks++; if (imem_req_out !== 1'b0 || pc_advance_out !== 1'b0)
      begin errors++; $display("FAIL rmid_forced got req=%b adv=%b exp 0 0", imem_req_out, pc_advance_out); end
    tick();
    rst_in         = 1'b1;
    pc_in          = 32'h300;
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", imem_req_out); end
    tick();
    imem_rvalid_in = 1'b0;
    #1;
    checks++; if (instr_valid_out !== 1'b0 || instr_pc_out !== 32'h0 || instr_out !== NOP)
      begin errors++; $display("FAIL rmid_ignored got v=%b pc=%h i=%h exp 0 00000000 00000013", instr_valid_out, instr_pc_out, instr_out); end
    checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h300)
      begin errors++; $display("FAIL rmid_still_req got req=%b addr=%h exp 1 00000300", imem_req_out, imem_addr_out); end
  endtask

  // PC register + single-port memory model; every presented entry must be the
  // word at the current PC, and the PC only moves on advance or redirect.
  task automatic test_random();
    logic [31:0] pc_reg, pend_addr;
    logic        pend, exp_adv, new_grant;
    int          lat, presented;
    pc_reg = 32'h0; pend = 1'b0; lat = 0; pend_addr = '0; presented = 0;
    do_reset(32'h0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc_in          = pc_reg;
      stall_in       = ($urandom_range(0, 3) == 0);
      flush_in       = ($urandom_range(0, 19) == 0);
      imem_rvalid_in = pend && (lat == 0);
      imem_rdata_in  = imem_rvalid_in ? mem_word(pend_addr) : $urandom;
      imem_gnt_in    = $urandom_range(0, 1) == 1;
      #1;
      exp_adv = instr_valid_out && !stall_in && !flush_in;
      checks++; if (pc_advance_out !== exp_adv)
        begin errors++; $display("FAIL rnd_adv cyc %0d got %b exp %b", cyc, pc_advance_out, exp_adv); end
      if (instr_valid_out === 1'b1) begin
        checks++; if (instr_pc_out !== pc_reg || instr_out !== mem_word(pc_reg) || misaligned_out !== 1'b0)
          begin errors++; $display("FAIL rnd_entry cyc %0d got pc=%h i=%h m=%b exp %h %h 0", cyc, instr_pc_out, instr_out, misaligned_out, pc_reg, mem_word(pc_reg)); end
      end
      if (imem_req_out === 1'b1) begin
        checks++; if (imem_addr_out !== pc_reg || pend || flush_in)
          begin errors++; $display("FAIL rnd_req cyc %0d got addr=%h pend=%b fl=%b exp %h 0 0", cyc, imem_addr_out, pend, flush_in, pc_reg); end
      end
      new_grant = imem_req_out && imem_gnt_in;
      tick();
      if (imem_rvalid_in) pend = 1'b0;
      else if (pend) lat--;
      if (new_grant) begin pend = 1'b1; lat = $urandom_range(0, 2); pend_addr = pc_reg; end
      if (flush_in) pc_reg = 32'($urandom_range(0, 1023)) << 2;
      else if (exp_adv) begin pc_reg = pc_reg + 32'd4; presented++; end
    end
    idle_inputs();
    checks++; if (presented < 100) begin errors++; $display("FAIL rnd_progress got %0d exp >=100", presented); end
  endtask

  initial begin
    rst_in = 1'b0;
    pc_in  = '0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_stall();
    test_flush_inflight();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
